// File: rtl/grid_pkg.sv
// Shared encodings for the maze grid: cell states, packet op codes, RGB332 colours and grid size.
package grid_pkg;

  localparam int unsigned GRID_ROWS = 4;
  localparam int unsigned GRID_COLS = 5;

  typedef enum logic [1:0] {
    CellUnvisited = 2'b00,
    CellVisited   = 2'b01,
    CellTreasure  = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    OpMove     = 2'b00,
    OpTreasure = 2'b01,
    OpClear    = 2'b10,
    OpRsvd     = 2'b11
  } op_e;

  localparam logic [7:0] COLOR_UNVISITED = 8'hFF;
  localparam logic [7:0] COLOR_VISITED   = 8'h1C;
  localparam logic [7:0] COLOR_TREASURE  = 8'h03;
  localparam logic [7:0] COLOR_CUR       = 8'hE0;
  localparam logic [7:0] COLOR_OFF       = 8'h00;

  function automatic logic [7:0] state_color(input cell_e s);
    case (s)
      CellUnvisited: return COLOR_UNVISITED;
      CellVisited:   return COLOR_VISITED;
      CellTreasure:  return COLOR_TREASURE;
      default:       return COLOR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/grid_state_updater_if.sv
// Arduino packet input, colour read port and status outputs of the grid state updater.
interface grid_state_updater_if;
  logic [7:0] DATA_IN;
  logic       DATA_VALID;
  logic [2:0] RD_X;
  logic [2:0] RD_Y;
  logic [7:0] RD_COLOR;
  logic       BUSY;
  logic       ERR;
  logic       CUR_VALID;
  logic [2:0] CUR_X;
  logic [2:0] CUR_Y;
  logic [4:0] VISITED_CNT;

  modport master (
    output DATA_IN, DATA_VALID, RD_X, RD_Y,
    input  RD_COLOR, BUSY, ERR, CUR_VALID, CUR_X, CUR_Y, VISITED_CNT
  );

  modport slave (
    input  DATA_IN, DATA_VALID, RD_X, RD_Y,
    output RD_COLOR, BUSY, ERR, CUR_VALID, CUR_X, CUR_Y, VISITED_CNT
  );
endinterface

// File: rtl/gpio_byte_sync.sv
// Two-flop synchroniser for the Arduino byte and strobe; emits a 1-cycle strobe on the strobe rise.
module gpio_byte_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] byte_out,
  output logic       byte_stb
);
  logic [7:0] d1_q, d2_q;
  logic       v1_q, v2_q, v3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      d1_q <= data_in;
      d2_q <= d1_q;
      v1_q <= valid_in;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  assign byte_out = d2_q;
  assign byte_stb = v2_q & ~v3_q;
endmodule

// File: rtl/grid_state_updater.sv
// Maze cell-state array fed by Arduino packets, with a registered colour read port.
// Optional current-cell blink is built when CURRENT_BLINK_EN is defined.
module grid_state_updater
  import grid_pkg::*;
#(
  parameter int unsigned ROWS       = GRID_ROWS,
  parameter int unsigned COLS       = GRID_COLS,
  parameter int unsigned BLINK_HALF = 12500000
) (
  input logic                 CLOCK,
  input logic                 RESET,
  grid_state_updater_if.slave bus
);
  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned IW    = $clog2(NCELL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]    state_q;
  logic [7:0]    pkt_q;
  cell_e         cells_q [NCELL];
  logic          cur_valid_q;
  logic [2:0]    cur_x_q, cur_y_q;
  logic [4:0]    vcnt_q;
  logic          err_q;
  logic [IW-1:0] clr_idx_q;
  logic [7:0]    rd_color_q, rd_color_d;

  logic [7:0] sync_byte;
  logic       sync_stb;

  gpio_byte_sync u_sync (
    .clk      (CLOCK),
    .rst      (RESET),
    .data_in  (bus.DATA_IN),
    .valid_in (bus.DATA_VALID),
    .byte_out (sync_byte),
    .byte_stb (sync_stb)
  );

  op_e           pkt_op;
  logic [2:0]    pkt_x, pkt_y;
  logic          pkt_in_range, apply_ok, move_ok;
  logic [IW-1:0] pkt_idx;
  cell_e         cell_old;

  assign pkt_op       = op_e'(pkt_q[7:6]);
  assign pkt_x        = pkt_q[5:3];
  assign pkt_y        = pkt_q[2:0];
  assign pkt_in_range = ({1'b0, pkt_x} < 4'(ROWS)) && ({1'b0, pkt_y} < 4'(COLS));
  assign pkt_idx      = IW'(32'(pkt_x) * COLS + 32'(pkt_y));
  assign cell_old     = pkt_in_range ? cells_q[pkt_idx] : CellUnvisited;
  assign apply_ok     = (state_q == APPLY) && pkt_in_range &&
                        ((pkt_op == OpMove) || (pkt_op == OpTreasure));
  assign move_ok      = apply_ok && (pkt_op == OpMove);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      cur_valid_q <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      vcnt_q      <= '0;
      err_q       <= 1'b0;
      clr_idx_q   <= '0;
      for (int i = 0; i < int'(NCELL); i++) cells_q[i] <= CellUnvisited;
    end else begin
      // Any strobe that arrives while a packet or sweep is in flight is lost.
      if (sync_stb && (state_q != IDLE)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sync_stb) begin
            pkt_q   <= sync_byte;
            state_q <= APPLY;
          end
        end
        APPLY: begin
          state_q <= IDLE;
          if (apply_ok) begin
            if (pkt_op == OpTreasure) cells_q[pkt_idx] <= CellTreasure;
            else if (cell_old == CellUnvisited) cells_q[pkt_idx] <= CellVisited;
            if ((cell_old == CellUnvisited) && (vcnt_q < 5'(NCELL))) vcnt_q <= vcnt_q + 5'd1;
            if (move_ok) begin
              cur_x_q     <= pkt_x;
              cur_y_q     <= pkt_y;
              cur_valid_q <= 1'b1;
            end
          end else if (pkt_op == OpClear) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        CLEAR: begin
          cells_q[clr_idx_q] <= CellUnvisited;
          if (clr_idx_q == IW'(NCELL - 1)) begin
            state_q     <= IDLE;
            vcnt_q      <= '0;
            cur_valid_q <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic show_cur;

`ifdef CURRENT_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else if (move_ok) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= ~blink_ph_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign show_cur = blink_ph_q;
`else
  // Always true; the term only keeps BLINK_HALF referenced in this build.
  assign show_cur = (BLINK_HALF != 0) || 1'b1;
`endif

  logic          rd_in_range, rd_is_cur;
  logic [IW-1:0] rd_idx;

  assign rd_in_range = ({1'b0, bus.RD_X} < 4'(ROWS)) && ({1'b0, bus.RD_Y} < 4'(COLS));
  assign rd_idx      = IW'(32'(bus.RD_X) * COLS + 32'(bus.RD_Y));
  assign rd_is_cur   = cur_valid_q && (bus.RD_X == cur_x_q) && (bus.RD_Y == cur_y_q);

  always_comb begin
    rd_color_d = COLOR_OFF;
    if (rd_in_range) begin
      rd_color_d = state_color(cells_q[rd_idx]);
      if (rd_is_cur && show_cur) rd_color_d = COLOR_CUR;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) rd_color_q <= COLOR_OFF;
    else       rd_color_q <= rd_color_d;
  end

  assign bus.RD_COLOR    = rd_color_q;
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.ERR         = err_q;
  assign bus.CUR_VALID   = cur_valid_q;
  assign bus.CUR_X       = cur_x_q;
  assign bus.CUR_Y       = cur_y_q;
  assign bus.VISITED_CNT = vcnt_q;
endmodule
